uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver that is the downstream consumer of the UART transmitter's Tx_out line.
- Frame format matches the transmitter exactly: start bit 0, `width` data bits LSB first, optional parity bit, one stop bit 1; line idles high.
- Runs on an oversampling clock at Prescale × bit rate.
- Each bit is recovered by 3-sample majority vote; the block emits a parallel word with a one-cycle valid pulse plus error flags.

Parameters:
- width, 8, number of data bits per frame.
- PRESC_W, 6, width of the Prescale input.

Ports:
- CLK  in  1  oversampling clock.
- Reset  in  1  asynchronous active-low reset.
- Rx_in  in  1  serial line, idle high, asynchronous to CLK.
- Prescale  in  PRESC_W  CLK cycles per bit; legal values are even and 8..2^PRESC_W-2.
- Parity_EN  in  1  1 means the frame carries a parity bit.
- Parity_type  in  1  0 = even, 1 = odd (total ones including the parity bit).
- P_Data  out  width  last good received word.
- Data_valid  out  1  one-cycle pulse when P_Data is updated.
- Parity_error  out  1  one-cycle pulse on parity mismatch.
- Stop_error  out  1  one-cycle pulse when the stop bit is sampled 0.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE; all counters are cleared.
  - P_Data=0, Data_valid=0, Parity_error=0, Stop_error=0.
  - Both synchronizer flops are set to 1.
  - Reset mid-frame discards the frame; no pulses are emitted.
- Input path: Rx_in passes through a 2-flop synchronizer; the FSM sees only the synchronized signal rx_s.
- Configuration capture: Prescale, Parity_EN and Parity_type are latched at start detection. Changes mid-frame have no effect.
- Counters:
  - edge_cnt counts 0..P-1 within a bit, then wraps to 0 and advances the bit.
  - bit_cnt counts data bits 0..width-1.
- Sampling: rx_s is sampled when edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, decided in the cycle with edge_cnt = P/2+1.
- FSM states and transitions:
  - IDLE: when rx_s=0, go to START with edge_cnt=0.
  - START:
    - If the decided bit is 1 (glitch), return to IDLE immediately with no pulse.
    - Otherwise, at edge_cnt=P-1, go to DATA.
  - DATA: each decided bit is shifted in LSB first. After bit width-1 finishes its last edge (P-1), go to PARITY if Parity_EN, else go to STOP.
  - PARITY:
    - The decided bit is compared with the expected parity of the shift register: even gives ^data, odd gives ~^data.
    - A mismatch sets an internal error flag.
    - At P-1, go to STOP.
  - STOP:
    - At the decision cycle, go to IDLE without waiting for the end of the bit, so back-to-back frames are accepted.
    - Outputs are registered on the next edge:
      - stop bit 1 and no parity error: P_Data is updated and Data_valid pulses.
      - parity error: Parity_error pulses; P_Data is held.
      - stop bit 0: Stop_error pulses; P_Data is held.
      - Both error pulses may occur in the same cycle; Data_valid is then 0.
- Latency: Data_valid is high in the cycle starting (N-1)·P + P/2 + 4 clock edges after the first edge that samples Rx_in low, where N is the number of frame bits (N = width+2, plus 1 if parity is enabled).
- A falling edge during the STOP decision cycle is ignored. Detection resumes in IDLE on the next cycle.
- All outputs are registered.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP) as localparams;
  - the majority-sample offsets (-1, 0, +1 relative to P/2).
- One natural sub-module, rx_data_sampler, containing:
  - the synchronizer;
  - edge_cnt compare logic;
  - the 3-sample majority vote.
  - Its outputs are sampled_bit and bit_decided.
- The FSM, shift register and output registers stay in uart_rx.

Test Plan:
- Frame 0xA5, Prescale=8, Parity_EN=0 → P_Data=0xA5 with a single Data_valid pulse at edge 80 after the start-bit falling sample; no error pulses.
- Frame 0x37, Prescale=16, even parity, parity bit 1 → P_Data=0x37 with Data_valid. Repeat with parity bit 0 → Parity_error pulse, no Data_valid, P_Data stays 0x37.
- Frame 0x5A, Prescale=8, stop bit driven 0 → Stop_error pulse only; P_Data unchanged.
- Rx_in low for 2 clocks then high, Prescale=8 → FSM returns to IDLE after START; no pulses. A following 0x81 frame is received correctly.
- Frames 0x00 then 0xFF back-to-back with zero idle gap, Prescale=16, odd parity → two Data_valid pulses, P_Data=0x00 then 0xFF, no errors.
- Reset asserted during DATA bit 3 of frame 0xC3, Prescale=8 → all outputs 0 immediately. The next frame 0x3C gives P_Data=0x3C with a single Data_valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx shared definitions: FSM state encoding, majority-vote
// sample offsets around the bit centre, and the 2-of-3 vote helper.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_e;

    // Sample points relative to P/2 within a bit period
    localparam int SAMP_OFS_EARLY = -1;
    localparam int SAMP_OFS_MID   = 0;
    localparam int SAMP_OFS_LATE  = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_data_sampler.sv
// Synchronizes the serial line and recovers each bit by 2-of-3 vote.
// Ports: CLK, Reset (async low), Rx_in (raw line), presc_i (latched
// prescale), edge_cnt_i (position within bit) -> rx_s_o (synchronized
// line), sampled_bit_o (voted bit), bit_decided_o (vote valid this cycle).
module rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Rx_in,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [PRESC_W-1:0] edge_cnt_i,
    output logic               rx_s_o,
    output logic               sampled_bit_o,
    output logic               bit_decided_o
);

    logic               sync1_q;
    logic               sync2_q;
    logic               samp_a_q;
    logic               samp_b_q;
    logic [PRESC_W-1:0] half;
    logic               at_early;
    logic               at_mid;
    logic               at_late;

    assign half     = presc_i >> 1;
    assign at_early = (edge_cnt_i == half + PRESC_W'(SAMP_OFS_EARLY));
    assign at_mid   = (edge_cnt_i == half + PRESC_W'(SAMP_OFS_MID));
    assign at_late  = (edge_cnt_i == half + PRESC_W'(SAMP_OFS_LATE));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            sync1_q <= Rx_in;
            sync2_q <= sync1_q;
            if (at_early) samp_a_q <= sync2_q;
            if (at_mid)   samp_b_q <= sync2_q;
        end
    end

    // Third sample is the live synchronized value, so the vote is
    // available combinationally in the late-sample cycle.
    assign rx_s_o        = sync2_q;
    assign sampled_bit_o = maj3(samp_a_q, samp_b_q, sync2_q);
    assign bit_decided_o = at_late;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing on an oversampled clock.
// Ports: CLK, Reset (async low), Rx_in, Prescale, Parity_EN, Parity_type
// -> P_Data (last good word), Data_valid, Parity_error, Stop_error pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int width   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Rx_in,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               Parity_EN,
    input  logic               Parity_type,
    output logic [width-1:0]   P_Data,
    output logic               Data_valid,
    output logic               Parity_error,
    output logic               Stop_error
);

    localparam int BCW = (width > 1) ? $clog2(width) : 1;

    state_e             state_q,    state_d;
    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [PRESC_W-1:0] presc_q,    presc_d;
    logic               pen_q,      pen_d;
    logic               ptype_q,    ptype_d;
    logic [width-1:0]   shift_q,    shift_d;
    logic               par_err_q,  par_err_d;
    logic [width-1:0]   pdata_q,    pdata_d;
    logic               dv_q,       dv_d;
    logic               pe_q,       pe_d;
    logic               se_q,       se_d;

    logic               rx_s;
    logic               samp_bit;
    logic               decided;
    logic               edge_last;
    logic               exp_par;
    logic [width:0]     shift_in;

    rx_data_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .CLK           (CLK),
        .Reset         (Reset),
        .Rx_in         (Rx_in),
        .presc_i       (presc_q),
        .edge_cnt_i    (edge_cnt_q),
        .rx_s_o        (rx_s),
        .sampled_bit_o (samp_bit),
        .bit_decided_o (decided)
    );

    assign edge_last = (edge_cnt_q == presc_q - 1'b1);
    assign exp_par   = ptype_q ? ~^shift_q : ^shift_q;
    assign shift_in  = {samp_bit, shift_q};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            presc_q    <= '0;
            pen_q      <= 1'b0;
            ptype_q    <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            presc_q    <= presc_d;
            pen_q      <= pen_d;
            ptype_q    <= ptype_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        presc_d    = presc_q;
        pen_d      = pen_q;
        ptype_d    = ptype_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s) begin
                    state_d   = START;
                    presc_d   = Prescale;
                    pen_d     = Parity_EN;
                    ptype_d   = Parity_type;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                if (decided && samp_bit) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (edge_last) begin
                    state_d    = DATA;
                    edge_cnt_d = '0;
                end
            end
            DATA: begin
                if (decided) shift_d = shift_in[width:1];
                if (edge_last) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == BCW'(width - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = pen_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decided) par_err_d = (samp_bit != exp_par);
                if (edge_last) begin
                    state_d    = STOP;
                    edge_cnt_d = '0;
                end
            end
            STOP: begin
                // Leave at the decision point so a start bit right after
                // the stop bit is still caught.
                if (decided) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    se_d       = ~samp_bit;
                    pe_d       = par_err_q;
                    dv_d       = samp_bit & ~par_err_q;
                    if (samp_bit && !par_err_q) pdata_d = shift_q;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    assign P_Data       = pdata_q;
    assign Data_valid   = dv_q;
    assign Parity_error = pe_q;
    assign Stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus
// hand-written glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       Rx_in = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       Parity_EN = 1'b0;
    logic       Parity_type = 1'b0;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Parity_error;
    logic       Stop_error;

    uart_rx #(
        .width   (8),
        .PRESC_W (6)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Rx_in        (Rx_in),
        .Prescale     (Prescale),
        .Parity_EN    (Parity_EN),
        .Parity_type  (Parity_type),
        .P_Data       (P_Data),
        .Data_valid   (Data_valid),
        .Parity_error (Parity_error),
        .Stop_error   (Stop_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         dv_n = 0;
    int         pe_n = 0;
    int         se_n = 0;
    int         last_dv_cyc = 0;
    logic [7:0] dv_hist[$];

    always @(negedge CLK) begin
        if (Data_valid) begin
            dv_n = dv_n + 1;
            last_dv_cyc = cyc;
            dv_hist.push_back(P_Data);
        end
        if (Parity_error) pe_n = pe_n + 1;
        if (Stop_error)   se_n = se_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         pen;
        bit         ptype;
        bit         pflip;
        bit         stopb;
        int         e_dv;
        int         e_pe;
        int         e_se;
        logic [7:0] e_pd;
        int         e_lat;
    } vec_t;

    vec_t vecs[5];
    int   tests = 0;
    int   fails = 0;
    int   t_start = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; holds the bit for p clocks.
    task automatic send_bit(input logic b, input int p);
        Rx_in = b;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p,
                              input bit pen, input bit ptype,
                              input bit pflip, input bit stopb);
        logic pb;
        Prescale    = p[5:0];
        Parity_EN   = pen;
        Parity_type = ptype;
        t_start = cyc + 1;
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        pb = (ptype ? ~^d : ^d) ^ pflip;
        if (pen) send_bit(pb, p);
        send_bit(stopb, p);
        Rx_in = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int dv0;
        int pe0;
        int se0;
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        send_frame(v.d, v.p, v.pen, v.ptype, v.pflip, v.stopb);
        repeat (3 * v.p) @(posedge CLK);
        #1;
        chk({nm, "_dv"}, dv_n - dv0, v.e_dv);
        chk({nm, "_pe"}, pe_n - pe0, v.e_pe);
        chk({nm, "_se"}, se_n - se0, v.e_se);
        chk({nm, "_pdata"}, int'(P_Data), int'(v.e_pd));
        if (v.e_lat != 0)
            chk({nm, "_lat"}, last_dv_cyc - t_start, v.e_lat);
    endtask

    initial begin
        int   dv0;
        int   pe0;
        int   se0;
        int   q0;
        vec_t v81;
        vec_t v3c;

        //        d      p   pen pty flip stp dv pe se pd     lat
        vecs[0] = '{8'hA5, 8,  0, 0, 0, 1, 1, 0, 0, 8'hA5, 80};
        vecs[1] = '{8'h37, 16, 1, 0, 0, 1, 1, 0, 0, 8'h37, 172};
        vecs[2] = '{8'h37, 16, 1, 0, 1, 1, 0, 1, 0, 8'h37, 0};
        vecs[3] = '{8'h5A, 8,  0, 0, 0, 0, 0, 0, 1, 8'h37, 0};
        vecs[4] = '{8'h12, 8,  1, 0, 1, 0, 0, 1, 1, 8'h37, 0};
        v81     = '{8'h81, 8,  1, 1, 0, 1, 1, 0, 0, 8'h81, 88};
        v3c     = '{8'h3C, 8,  0, 0, 0, 1, 1, 0, 0, 8'h3C, 80};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pdata", int'(P_Data), 0);
        chk("rst_dv", int'(Data_valid), 0);
        chk("rst_pe", int'(Parity_error), 0);
        chk("rst_se", int'(Stop_error), 0);
        Reset = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Two-clock low glitch: START entered, then abandoned.
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        Prescale  = 6'd8;
        Parity_EN = 1'b0;
        Rx_in = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Rx_in = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("glitch_start", int'(dut.state_q), int'(START));
        repeat (6) @(posedge CLK);
        #1;
        chk("glitch_idle", int'(dut.state_q), int'(IDLE));
        repeat (16) @(posedge CLK);
        #1;
        chk("glitch_pulses", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
        run_vec(v81, "after_glitch");

        // Back-to-back frames, no idle gap, odd parity.
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        q0  = dv_hist.size();
        send_frame(8'h00, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (48) @(posedge CLK);
        #1;
        chk("b2b_dv", dv_n - dv0, 2);
        chk("b2b_err", (pe_n - pe0) + (se_n - se0), 0);
        if (dv_hist.size() >= q0 + 2) begin
            chk("b2b_first", int'(dv_hist[q0]), 8'h00);
            chk("b2b_second", int'(dv_hist[q0 + 1]), 8'hFF);
        end else begin
            chk("b2b_hist", dv_hist.size() - q0, 2);
        end

        // Reset during data bit 3 of 0xC3.
        dv0 = dv_n;
        pe0 = pe_n;
        se0 = se_n;
        Prescale  = 6'd8;
        Parity_EN = 1'b0;
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        Rx_in = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        Reset = 1'b0;
        #1;
        chk("midrst_pdata", int'(P_Data), 0);
        chk("midrst_dv", int'(Data_valid), 0);
        chk("midrst_pe", int'(Parity_error), 0);
        chk("midrst_se", int'(Stop_error), 0);
        Rx_in = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        run_vec(v3c, "after_rst");
        chk("midrst_total_dv", dv_n - dv0, 1);
        chk("midrst_total_err", (pe_n - pe0) + (se_n - se0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
